ifetch_prefetch_unit: RTL and testbench



---
 rtl/ifetch_prefetch_unit_pkg.sv | 21 ++
 rtl/ifetch_prefetch_unit_fetch_queue.sv | 45 ++++
 rtl/ifetch_prefetch_unit.sv | 98 +++++++++
 tb/tb_ifetch_prefetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: none (types only); backpressure: n/a.
package ifetch_prefetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000020;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ALU = 6'h00;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/ifetch_prefetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetch entries; flush beats push/pop.
// Latency: a push is visible at head the next cycle; backpressure: caller never pushes when full.
module fetch_queue
    import ifetch_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW:0]    count_q;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally at DEPTH.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Sequential fetch with one outstanding request, epoch-tagged flush on redirect, prefetch queue to decode.
// Latency: response word reaches id_* one cycle after it returns; backpressure: credit stops issue when queue+in-flight fill DEPTH.
module ifetch_prefetch_unit
    import ifetch_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         outst_q, outst_d;
    logic         tag_q, tag_d;
    logic         epoch_q, epoch_d;

    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          accept, rsp, push, pop;

    // Queued plus in-flight entries never exceed DEPTH, so a response always has room.
    assign inflight  = {1'b0, count} + {{CW{1'b0}}, outst_q};
    assign imem_req  = ~reset & ~redirect & (~outst_q | imem_rvalid) & (inflight < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;

    assign accept    = imem_req & imem_ready;
    assign rsp       = imem_rvalid & outst_q;
    assign push      = rsp & (tag_q == epoch_q) & ~redirect;
    assign push_data = '{pc: req_pc_q, instr: imem_rdata};

    assign id_valid  = (count != '0) & ~redirect & ~reset;
    assign pop       = id_valid & id_ready;
    assign id_instr  = id_valid ? head.instr : NOP_INSTR;
    assign id_pc     = id_valid ? head.pc : 32'h0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        tag_d      = tag_q;
        epoch_d    = epoch_q;
        outst_d    = outst_q;
        if (redirect) begin
            fetch_pc_d = {word_addr(redirect_pc), 2'b00};
            epoch_d    = ~epoch_q;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
            tag_d      = epoch_q;
        end
        if (accept)   outst_d = 1'b1;
        else if (rsp) outst_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= PC_RESET;
            req_pc_q   <= '0;
            outst_q    <= 1'b0;
            tag_q      <= 1'b0;
            epoch_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            outst_q    <= outst_d;
            tag_q      <= tag_d;
            epoch_q    <= epoch_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Bench for ifetch_prefetch_unit: variable-latency memory model plus a pop scoreboard.
module tb_ifetch_prefetch_unit;
    import ifetch_prefetch_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    int n_accept = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pending[$];
    fetch_entry_t sb[$];

    ifetch_prefetch_unit #(.DEPTH(4), .PC_RESET(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a >> 2) ^ {a[7:0], 24'h0};
    endfunction

    function automatic fetch_entry_t ent(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc = pc;
        e.instr = memw(pc);
        return e;
    endfunction

    // Memory responder and decode-side monitor, sampled mid-cycle.
    always @(negedge clock) begin : mon
        fetch_entry_t e;
        if (id_valid && id_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got pc=%h instr=%h, none expected", id_pc, id_instr);
            end else begin
                e = sb.pop_front();
                if (id_pc !== e.pc || id_instr !== e.instr) begin
                    failures++;
                    $display("FAIL pop_data got pc=%h instr=%h exp pc=%h instr=%h", id_pc, id_instr, e.pc, e.instr);
                end
            end
        end else if (!id_valid) begin
            checks++;
            if (id_instr !== NOP_INSTR || id_pc !== 32'h0) begin
                failures++;
                $display("FAIL idle_outputs got instr=%h pc=%h exp %h/0", id_instr, id_pc, NOP_INSTR);
            end
        end
        if (imem_req) begin
            checks++;
            if (imem_addr[1:0] !== 2'b00) begin
                failures++;
                $display("FAIL addr_align got %h exp low bits 00", imem_addr);
            end
        end
        if (imem_rvalid && pending.size() > 0) void'(pending.pop_front());
        if (imem_req && imem_ready) begin
            pending.push_back('{addr: imem_addr, due: cyc + lat});
            n_accept++;
        end
        if (reset) pending.delete();
    end

    always @(posedge clock) begin
        cyc++;
        #1;
        if (pending.size() > 0 && cyc >= pending[0].due) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memw(pending[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; id_ready = 1'b0; imem_ready = 1'b1; lat = 1;
        tick(3);
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic pop_one();
        tick(1); id_ready = 1'b1;
        tick(1); id_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b exp 0", id_valid); end
        do_reset();
        sb.push_back(ent(32'h0)); sb.push_back(ent(32'h4));
        sb.push_back(ent(32'h8)); sb.push_back(ent(32'hC));
        id_ready = 1'b1;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
        tick(1);
        @(negedge clock);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL early_valid got %b exp 0", id_valid); end
        tick(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got %b exp 1", i, id_valid); end
            tick(1);
        end
        id_ready = 1'b0;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL reset_drain left=%0d exp 0", sb.size()); end
    endtask

    task automatic test_stall();
        int a0;
        do_reset();
        a0 = n_accept;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL stall_pc[%0d] got %h exp 0", i, id_pc); end
            tick(1);
        end
        @(negedge clock);
        checks++; if (n_accept - a0 != 4) begin failures++; $display("FAIL stall_fetches got %0d exp 4", n_accept - a0); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got %b exp 0", imem_req); end
        checks++; if (id_instr !== memw(32'h0)) begin failures++; $display("FAIL stall_head got %h exp %h", id_instr, memw(32'h0)); end
        sb.push_back(ent(32'h0)); sb.push_back(ent(32'h4));
        sb.push_back(ent(32'h8)); sb.push_back(ent(32'hC));
        tick(1);
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got %b exp 1", i, id_valid); end
            tick(1);
        end
        id_ready = 1'b0;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL stall_drain left=%0d exp 0", sb.size()); end
    endtask

    task automatic test_redirect_latency();
        bit found = 0;
        do_reset();
        lat = 3;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (pending.size() > 0 && pending[0].addr == 32'h8) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL lat_fetch8 got none exp fetch of 00000008"); end
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clock);
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL lat_redir_cycle got valid=%b req=%b exp 0/0", id_valid, imem_req); end
        tick(1);
        redirect = 1'b0;
        sb.push_back(ent(32'h40));
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clock);
            if (id_valid) found = 1;
        end
        checks++; if (!found || id_pc !== 32'h40) begin failures++; $display("FAIL lat_first_pc got valid=%b pc=%h exp 1/00000040", found, id_pc); end
        pop_one();
        lat = 1;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL lat_drain left=%0d exp 0", sb.size()); end
    endtask

    task automatic test_redirect_align();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL align_req got %b exp 0", imem_req); end
        tick(1);
        redirect = 1'b0;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL align_addr got req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_rvalid();
        bit found = 0;
        do_reset();
        tick(1);
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clock);
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rv_redir_cycle got valid=%b req=%b exp 0/0", id_valid, imem_req); end
        tick(1);
        redirect = 1'b0;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rv_resume got req=%b addr=%h exp 1/00000200", imem_req, imem_addr); end
        sb.push_back(ent(32'h200));
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (id_valid) found = 1;
        end
        checks++; if (!found || id_pc !== 32'h200) begin failures++; $display("FAIL rv_first_pc got valid=%b pc=%h exp 1/00000200", found, id_pc); end
        pop_one();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rv_drain left=%0d exp 0", sb.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        @(negedge clock);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top got %h exp fffffffc", imem_addr); end
        tick(1);
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_zero got req=%b addr=%h exp 1/00000000", imem_req, imem_addr); end
        sb.push_back(ent(32'hFFFF_FFFC)); sb.push_back(ent(32'h0));
        tick(4);
        id_ready = 1'b1;
        tick(2);
        id_ready = 1'b0;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL wrap_drain left=%0d exp 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        do_reset();
        tick(3);
        @(negedge clock);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin failures++; $display("FAIL mid_prefill got valid=%b pc=%h exp 1/0", id_valid, id_pc); end
        tick(1);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL mid_rst_cycle got valid=%b req=%b exp 0/0", id_valid, imem_req); end
        tick(1);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (id_valid !== 1'b0 || id_instr !== NOP_INSTR) begin failures++; $display("FAIL mid_after got valid=%b instr=%h exp 0/%h", id_valid, id_instr, NOP_INSTR); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mid_first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
        sb.push_back(ent(32'h0));
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (id_valid) found = 1;
        end
        checks++; if (!found || id_pc !== 32'h0) begin failures++; $display("FAIL mid_first_pc got valid=%b pc=%h exp 1/0", found, id_pc); end
        pop_one();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_drain left=%0d exp 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_latency();
        test_redirect_align();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
